// File: rtl/gate_truth_sweeper.sv
// Drives a 2-input gate through 00,01,10,11, samples its output after a settle window
// and scores it against TRUTH. Optional first-fail capture: GATE_SWEEP_FIRSTFAIL_EN.
module gate_truth_sweeper #(
   parameter logic [3:0] TRUTH  = 4'b0001,
   parameter int         SETTLE = 2,
   parameter int         ERR_W  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             a_o,
   output logic             b_o,
   input  logic             c_i,
   output logic             busy,
   output logic             done,
   output logic             pass,
`ifdef GATE_SWEEP_FIRSTFAIL_EN
   output logic [1:0]       first_fail,
   output logic             first_fail_vld,
`endif
   output logic [ERR_W-1:0] err_cnt
);

   localparam int               CNT_W    = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE);

   typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

   state_t           state, state_nxt;
   logic [1:0]       idx, idx_nxt;
   logic [1:0]       vec, vec_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             busy_nxt, done_nxt, pass_nxt;
   logic [ERR_W-1:0] err_nxt, err_upd;
   logic             mismatch;
`ifdef GATE_SWEEP_FIRSTFAIL_EN
   logic [1:0]       ff_nxt;
   logic             ff_vld_nxt;
`endif

   assign a_o = vec[1];
   assign b_o = vec[0];

   assign mismatch = (c_i != TRUTH[idx]);
   assign err_upd  = (mismatch && (err_cnt != '1)) ? err_cnt + ERR_W'(1) : err_cnt;

   always_comb begin
      // NOTE: every next-state signal gets its hold value first, so no path through the case infers a latch.
      state_nxt = state;
      idx_nxt   = idx;
      vec_nxt   = vec;
      cnt_nxt   = cnt;
      busy_nxt  = busy;
      done_nxt  = done;
      pass_nxt  = pass;
      err_nxt   = err_cnt;
`ifdef GATE_SWEEP_FIRSTFAIL_EN
      ff_nxt     = first_fail;
      ff_vld_nxt = first_fail_vld;
`endif
      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_nxt = DRIVE;
               idx_nxt   = 2'd0;
               vec_nxt   = 2'd0;
               cnt_nxt   = CNT_INIT;
               err_nxt   = '0;
               busy_nxt  = 1'b1;
               done_nxt  = 1'b0;
               pass_nxt  = 1'b0;
`ifdef GATE_SWEEP_FIRSTFAIL_EN
               ff_nxt     = 2'd0;
               ff_vld_nxt = 1'b0;
`endif
            end
         end
         DRIVE: begin
            if (cnt != '0) begin
               cnt_nxt = cnt - CNT_W'(1);
            end else begin
               err_nxt = err_upd;
`ifdef GATE_SWEEP_FIRSTFAIL_EN
               if (mismatch && !first_fail_vld) begin
                  ff_nxt     = idx;
                  ff_vld_nxt = 1'b1;
               end
`endif
               if (idx != 2'd3) begin
                  idx_nxt = idx + 2'd1;
                  vec_nxt = idx + 2'd1;
                  cnt_nxt = CNT_INIT;
               end else begin
                  // The verdict must include this edge's compare, so it uses err_upd.
                  state_nxt = DONE;
                  busy_nxt  = 1'b0;
                  done_nxt  = 1'b1;
                  vec_nxt   = 2'd0;
                  pass_nxt  = (err_upd == '0);
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         idx     <= 2'd0;
         vec     <= 2'd0;
         cnt     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         pass    <= 1'b0;
         err_cnt <= '0;
`ifdef GATE_SWEEP_FIRSTFAIL_EN
         first_fail     <= 2'd0;
         first_fail_vld <= 1'b0;
`endif
      end else begin
         state   <= state_nxt;
         idx     <= idx_nxt;
         vec     <= vec_nxt;
         cnt     <= cnt_nxt;
         busy    <= busy_nxt;
         done    <= done_nxt;
         pass    <= pass_nxt;
         err_cnt <= err_nxt;
`ifdef GATE_SWEEP_FIRSTFAIL_EN
         first_fail     <= ff_nxt;
         first_fail_vld <= ff_vld_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_gate_truth_sweeper.sv
// Scoreboard bench for gate_truth_sweeper: stimulus queues expected vectors and verdicts,
// a negedge monitor pops them whenever the DUT is busy or raises done.
`timescale 1ns/1ps
module tb_gate_truth_sweeper;

   localparam int SWEEP = 12;

   typedef struct {
      int         cyc;
      logic [3:0] err;
      logic       pss;
   } exp_t;

   typedef enum logic [1:0] {G_NOR, G_ZERO, G_OR, G_ONE} gate_t;

   logic       clk = 1'b0;
   logic       rst, start, start_s;
   logic       a_o, b_o, c_i, busy, done, pass;
   logic [3:0] err_cnt;
   logic       a_s, b_s, c_s, busy_s, done_s, pass_s;
   logic [1:0] err_s;
`ifdef GATE_SWEEP_FIRSTFAIL_EN
   logic [1:0] first_fail, first_fail_s;
   logic       first_fail_vld, first_fail_vld_s;
`endif

   gate_t      mode;
   int         cyc = 0;
   int         checks = 0;
   int         failures = 0;
   exp_t       sb[$];
   exp_t       sbs[$];
   logic [1:0] vq[$];
   logic       done_q = 1'b0;
   logic       done_s_q = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Gate cells under test: a selectable one for the main DUT, an OR gate for the narrow-counter DUT.
   always_comb begin
      case (mode)
         G_NOR:   c_i = ~(a_o | b_o);
         G_ZERO:  c_i = 1'b0;
         G_OR:    c_i = a_o | b_o;
         default: c_i = 1'b1;
      endcase
   end
   assign c_s = a_s | b_s;

   gate_truth_sweeper dut (
      .clk(clk), .rst(rst), .start(start),
      .a_o(a_o), .b_o(b_o), .c_i(c_i),
      .busy(busy), .done(done), .pass(pass),
`ifdef GATE_SWEEP_FIRSTFAIL_EN
      .first_fail(first_fail), .first_fail_vld(first_fail_vld),
`endif
      .err_cnt(err_cnt)
   );

   gate_truth_sweeper #(.ERR_W(2)) dut_sat (
      .clk(clk), .rst(rst), .start(start_s),
      .a_o(a_s), .b_o(b_s), .c_i(c_s),
      .busy(busy_s), .done(done_s), .pass(pass_s),
`ifdef GATE_SWEEP_FIRSTFAIL_EN
      .first_fail(first_fail_s), .first_fail_vld(first_fail_vld_s),
`endif
      .err_cnt(err_s)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Monitor: consumes expectations as the DUTs present vectors and verdicts.
   initial begin
      exp_t       e;
      logic [1:0] v;
      forever begin
         @(negedge clk);
         if (busy) begin
            if (vq.size() == 0) check("busy_unexpected", busy, 0);
            else begin
               v = vq.pop_front();
               check("vector_ab", {a_o, b_o}, v);
            end
         end
         if (done && !done_q) begin
            if (sb.size() == 0) check("done_unexpected", done, 0);
            else begin
               e = sb.pop_front();
               check("done_cycle", cyc, e.cyc);
               check("err_cnt", err_cnt, e.err);
               check("pass", pass, e.pss);
               check("ab_idle", {a_o, b_o}, 2'b00);
            end
         end
         if (done_s && !done_s_q) begin
            if (sbs.size() == 0) check("sat_done_unexpected", done_s, 0);
            else begin
               e = sbs.pop_front();
               check("sat_done_cycle", cyc, e.cyc);
               check("sat_err_cnt", err_s, e.err);
               check("sat_pass", pass_s, e.pss);
            end
         end
         done_q   = done;
         done_s_q = done_s;
      end
   end

   task automatic start_sweep(input logic [3:0] err, input logic pss);
      exp_t e;
      @(negedge clk); #1;
      start = 1'b1;
      e.cyc = cyc + 1 + SWEEP;
      e.err = err;
      e.pss = pss;
      sb.push_back(e);
      for (int k = 0; k < SWEEP; k++) vq.push_back(2'(k / 3));
      @(negedge clk); #1;
      start = 1'b0;
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while ((sb.size() + sbs.size() + vq.size()) != 0 && n < budget) begin
         @(negedge clk); #1;
         n++;
      end
      check("drain_timeout", sb.size() + sbs.size() + vq.size(), 0);
      sb.delete();
      sbs.delete();
      vq.delete();
   endtask

   initial begin
      exp_t e;
      int   n;
      rst = 1'b1; start = 1'b0; start_s = 1'b0; mode = G_NOR;
      #1;
      check("rst_a", a_o, 0);
      check("rst_b", b_o, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_pass", pass, 0);
      check("rst_err", err_cnt, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // 1: NOR gate, clean sweep; verdict held in DONE
      start_sweep(4'd0, 1'b1);
      drain(40);
      repeat (3) @(negedge clk);
      #1;
      check("done_held", done, 1);
      check("pass_held", pass, 1);

      // 2: output stuck at 0, only vector 00 mismatches
      mode = G_ZERO;
      start_sweep(4'd1, 1'b0);
      drain(40);

      // 3: 2-bit counter with an OR gate saturates at 3
      @(negedge clk); #1;
      start_s = 1'b1;
      e.cyc = cyc + 1 + SWEEP; e.err = 4'd3; e.pss = 1'b0;
      sbs.push_back(e);
      @(negedge clk); #1;
      start_s = 1'b0;
      drain(40);

      // 4: start re-pulsed while busy is ignored
      mode = G_NOR;
      start_sweep(4'd0, 1'b1);
      repeat (4) @(negedge clk);
      #1 start = 1'b1;
      @(negedge clk);
      #1 start = 1'b0;
      drain(40);

      // start held high: two back-to-back sweeps, done high for one cycle between them
      @(negedge clk); #1;
      start = 1'b1;
      e.cyc = cyc + 1 + SWEEP; e.err = 4'd0; e.pss = 1'b1;
      sb.push_back(e);
      e.cyc = cyc + 2 + 2 * SWEEP;
      sb.push_back(e);
      for (int k = 0; k < 2 * SWEEP; k++) vq.push_back(2'((k % SWEEP) / 3));
      repeat (14) @(negedge clk);
      #1 start = 1'b0;
      drain(60);

      // 5: reset during vector 10 abandons the sweep without a clock edge
      mode = G_ZERO;
      start_sweep(4'd0, 1'b0);
      n = 0;
      while ({a_o, b_o} != 2'b10 && n < 20) begin
         @(negedge clk); #1;
         n++;
      end
      check("reach_vec10", {a_o, b_o}, 2'b10);
      check("pre_rst_err", err_cnt, 1);
      #2 rst = 1'b1;
      #1;
      check("midrst_a", a_o, 0);
      check("midrst_b", b_o, 0);
      check("midrst_busy", busy, 0);
      check("midrst_err", err_cnt, 0);
      check("midrst_done", done, 0);
      sb.delete();
      vq.delete();
      rst = 1'b0;
      repeat (15) @(negedge clk);
      #1;
      check("post_rst_done", done, 0);
      check("post_rst_busy", busy, 0);
      mode = G_NOR;
      start_sweep(4'd0, 1'b1);
      drain(40);

      // 6: output stuck at 1 mismatches 01, 10, 11
      mode = G_ONE;
      start_sweep(4'd3, 1'b0);
      drain(40);
`ifdef GATE_SWEEP_FIRSTFAIL_EN
      check("first_fail", first_fail, 2'b01);
      check("first_fail_vld", first_fail_vld, 1);
`endif
      mode = G_NOR;
      start_sweep(4'd0, 1'b1);
      check("restart_done_drop", done, 0);
`ifdef GATE_SWEEP_FIRSTFAIL_EN
      check("ff_clear", first_fail, 2'b00);
      check("ff_vld_clear", first_fail_vld, 0);
`endif
      drain(40);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired at t=%0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
